// File: rtl/click_pkg.sv
// Shared click decoder types and command codes.
// Define CLICK_DECODER_TRIPLE_EN to allow triple-click detection (code 11).
package click_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PEND    = 2'd2
   } state_t;

   localparam logic [1:0] CMD_NONE   = 2'b00;
   localparam logic [1:0] CMD_SINGLE = 2'b01;
   localparam logic [1:0] CMD_DOUBLE = 2'b10;
   localparam logic [1:0] CMD_TRIPLE = 2'b11;

`ifdef CLICK_DECODER_TRIPLE_EN
   localparam logic [1:0] MAX_CLICKS = 2'd3;
`else
   localparam logic [1:0] MAX_CLICKS = 2'd2;
`endif

endpackage

// File: rtl/click_window_timer.sv
// Saturating idle-gap timer for the click decoder; tc flags the last cycle of the window.
module click_window_timer #(
   parameter int unsigned WINDOW_CYCLES = 25000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned    TW   = $clog2(WINDOW_CYCLES);
   localparam logic [TW-1:0]  LAST = TW'(WINDOW_CYCLES - 1);

   logic [TW-1:0] r_timer;
   logic          w_tc;

   assign w_tc = (r_timer == LAST);
   assign tc   = w_tc;

   // Holds at LAST rather than wrapping if the owner does not react to tc.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_timer <= '0;
      end else if (en && !w_tc) begin
         r_timer <= r_timer + TW'(1);
      end
   end

endmodule

// File: rtl/click_decoder.sv
// Groups click pulses into single/double(/triple) commands held until acknowledged.
// Triple-click support is enabled by defining CLICK_DECODER_TRIPLE_EN (see click_pkg).
module click_decoder
   import click_pkg::*;
#(
   parameter int unsigned WINDOW_CYCLES = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rising,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [1:0] cmd,
   output logic       busy,
   output logic       overrun
);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_count, w_count_nxt;
   logic [1:0] r_cmd, w_cmd_nxt;
   logic       r_overrun, w_overrun_nxt;
   logic [1:0] w_count_inc;
   logic       w_tc;
   logic       w_tmr_clr;
   logic       w_tmr_en;

   // Any click restarts the window; outside COLLECT the timer is parked at zero.
   assign w_tmr_clr = rising || (r_state != ST_COLLECT);
   assign w_tmr_en  = (r_state == ST_COLLECT);

   click_window_timer #(
      .WINDOW_CYCLES(WINDOW_CYCLES)
   ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (w_tmr_clr),
      .en  (w_tmr_en),
      .tc  (w_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_count   <= '0;
         r_cmd     <= CMD_NONE;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_cmd     <= w_cmd_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_cmd_nxt     = r_cmd;
      w_overrun_nxt = 1'b0;
      w_count_inc   = r_count + 2'd1;

      unique case (r_state)
         ST_IDLE: begin
            if (rising) begin
               w_state_nxt = ST_COLLECT;
               w_count_nxt = 2'd1;
            end
         end
         ST_COLLECT: begin
            // A click in the timeout cycle takes priority over the timeout.
            if (rising) begin
               if (w_count_inc == MAX_CLICKS) begin
                  w_state_nxt = ST_PEND;
                  w_cmd_nxt   = w_count_inc;
                  w_count_nxt = '0;
               end else begin
                  w_count_nxt = w_count_inc;
               end
            end else if (w_tc) begin
               w_state_nxt = ST_PEND;
               w_cmd_nxt   = r_count;
               w_count_nxt = '0;
            end
         end
         ST_PEND: begin
            if (cmd_ack) begin
               w_cmd_nxt = CMD_NONE;
               if (rising) begin
                  w_state_nxt = ST_COLLECT;
                  w_count_nxt = 2'd1;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (rising) begin
               w_overrun_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
            w_cmd_nxt   = CMD_NONE;
         end
      endcase
   end

   assign cmd_valid = (r_state == ST_PEND);
   assign busy      = (r_state == ST_COLLECT);
   assign cmd       = r_cmd;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder with WINDOW_CYCLES=10; follows CLICK_DECODER_TRIPLE_EN.
module tb_click_decoder;

   localparam int unsigned W = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rising = 1'b0;
   logic       cmd_ack = 1'b0;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic       busy;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   click_decoder #(
      .WINDOW_CYCLES(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rising    (rising),
      .cmd_ack   (cmd_ack),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic click();
      rising = 1'b1;
      step();
      rising = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; rising = 1'b0; cmd_ack = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic ack();
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({cmd_valid, cmd, busy, overrun} !== 5'b0) begin
         $display("FAIL reset_state got=%b exp=00000", {cmd_valid, cmd, busy, overrun});
         bad++;
      end
   endtask

   task automatic test_single();
      int early;
      do_reset();
      click();
      total++;
      if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
         $display("FAIL single_busy got busy=%b valid=%b exp busy=1 valid=0", busy, cmd_valid);
         bad++;
      end
      early = 0;
      for (int i = 1; i < W; i++) begin
         step();
         if (cmd_valid !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
         $display("FAIL single_early got early=%0d exp=0", early);
         bad++;
      end
      step();
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b01 || busy !== 1'b0) begin
         $display("FAIL single_timeout got valid=%b cmd=%b busy=%b exp 1 01 0", cmd_valid, cmd, busy);
         bad++;
      end
      steps(5);
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b01) begin
         $display("FAIL single_hold got valid=%b cmd=%b exp 1 01", cmd_valid, cmd);
         bad++;
      end
      ack();
      total++;
      if (cmd_valid !== 1'b0 || cmd !== 2'b00 || busy !== 1'b0) begin
         $display("FAIL single_ack got valid=%b cmd=%b busy=%b exp 0 00 0", cmd_valid, cmd, busy);
         bad++;
      end
      ack();
      total++;
      if ({cmd_valid, cmd, busy, overrun} !== 5'b0) begin
         $display("FAIL idle_ack_ignored got=%b exp=00000", {cmd_valid, cmd, busy, overrun});
         bad++;
      end
   endtask

   task automatic test_double();
      do_reset();
      click();
      steps(6);
      click();
`ifdef CLICK_DECODER_TRIPLE_EN
      total++;
      if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
         $display("FAIL double_collect got busy=%b valid=%b exp 1 0", busy, cmd_valid);
         bad++;
      end
      steps(W);
`endif
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b10) begin
         $display("FAIL double_cmd got valid=%b cmd=%b exp 1 10", cmd_valid, cmd);
         bad++;
      end
      ack();
   endtask

`ifdef CLICK_DECODER_TRIPLE_EN
   task automatic test_triple();
      int idle_busy;
      do_reset();
      idle_busy = 0;
      click();
      if (busy !== 1'b1) idle_busy++;
      for (int i = 0; i < 4; i++) begin step(); if (busy !== 1'b1) idle_busy++; end
      click();
      for (int i = 0; i < 6; i++) begin step(); if (busy !== 1'b1) idle_busy++; end
      total++;
      if (idle_busy != 0) begin
         $display("FAIL triple_busy got gaps=%0d exp=0", idle_busy);
         bad++;
      end
      click();
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b11 || busy !== 1'b0) begin
         $display("FAIL triple_cmd got valid=%b cmd=%b busy=%b exp 1 11 0", cmd_valid, cmd, busy);
         bad++;
      end
      ack();
   endtask
`endif

   task automatic test_click_wins();
      do_reset();
      click();
      steps(W - 1);
      total++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL edge_pre got valid=%b busy=%b exp 0 1", cmd_valid, busy);
         bad++;
      end
      click();
`ifdef CLICK_DECODER_TRIPLE_EN
      total++;
      if (cmd_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL edge_click_wins got valid=%b busy=%b exp 0 1", cmd_valid, busy);
         bad++;
      end
      steps(W);
`endif
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b10) begin
         $display("FAIL edge_count2 got valid=%b cmd=%b exp 1 10", cmd_valid, cmd);
         bad++;
      end
      ack();
   endtask

   task automatic test_overrun();
      do_reset();
      click();
      steps(W);
      rising = 1'b1;
      step();
      rising = 1'b0;
      total++;
      if (overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd !== 2'b01) begin
         $display("FAIL overrun_pulse got ovr=%b valid=%b cmd=%b exp 1 1 01", overrun, cmd_valid, cmd);
         bad++;
      end
      step();
      total++;
      if (overrun !== 1'b0 || cmd !== 2'b01) begin
         $display("FAIL overrun_single got ovr=%b cmd=%b exp 0 01", overrun, cmd);
         bad++;
      end
      rising = 1'b1; cmd_ack = 1'b1;
      step();
      rising = 1'b0; cmd_ack = 1'b0;
      total++;
      if (busy !== 1'b1 || cmd_valid !== 1'b0 || overrun !== 1'b0 || cmd !== 2'b00) begin
         $display("FAIL ack_click got busy=%b valid=%b ovr=%b cmd=%b exp 1 0 0 00", busy, cmd_valid, overrun, cmd);
         bad++;
      end
      click();
`ifdef CLICK_DECODER_TRIPLE_EN
      total++;
      if (busy !== 1'b1 || cmd_valid !== 1'b0) begin
         $display("FAIL ack_click_count got busy=%b valid=%b exp 1 0", busy, cmd_valid);
         bad++;
      end
`else
      total++;
      if (cmd_valid !== 1'b1 || cmd !== 2'b10) begin
         $display("FAIL ack_click_count got valid=%b cmd=%b exp 1 10", cmd_valid, cmd);
         bad++;
      end
`endif
   endtask

   task automatic test_reset_override();
      do_reset();
      click();
      steps(3);
      rst = 1'b1; rising = 1'b1;
      step();
      rst = 1'b0; rising = 1'b0;
      total++;
      if ({cmd_valid, cmd, busy, overrun} !== 5'b0) begin
         $display("FAIL rst_collect got=%b exp=00000", {cmd_valid, cmd, busy, overrun});
         bad++;
      end
      step();
      total++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         $display("FAIL rst_click_dropped got busy=%b valid=%b exp 0 0", busy, cmd_valid);
         bad++;
      end
      click();
      steps(W);
      rst = 1'b1; rising = 1'b1;
      step();
      rst = 1'b0; rising = 1'b0;
      total++;
      if ({cmd_valid, cmd, busy, overrun} !== 5'b0) begin
         $display("FAIL rst_pend got=%b exp=00000", {cmd_valid, cmd, busy, overrun});
         bad++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_double();
`ifdef CLICK_DECODER_TRIPLE_EN
      test_triple();
`endif
      test_click_wins();
      test_overrun();
      test_reset_override();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
